// File: rtl/iobus_timer_intc.sv
// iobus_timer_intc: memory-mapped down-counting timer with a 16-bit
// prescaler, one-shot / auto-reload modes and a level interrupt output.
// Register window (word offsets from BASE_ADDR):
//   0x00 CTRL   {IRQ_EN, AUTO, EN}
//   0x04 LOAD   reload value
//   0x08 COUNT  current count (read-only)
//   0x0C STATUS {RUNNING, PEND}; PEND is write-one-to-clear
//   0x10 PRESC  prescaler terminal value
`timescale 1ns/1ps

module iobus_timer_intc #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;      // [0] EN, [1] AUTO, [2] IRQ_EN
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] psc_q, psc_d;
  logic        pend_q, pend_d;
  logic        intr_q, intr_d;

  logic [31:0] offset_s;
  logic        wr_ctrl_s, wr_load_s, wr_status_s, wr_presc_s;
  logic        tick_s;

  // Address decode and combinational read-back; an unsigned offset makes
  // addresses below the base wrap far out of range, and only exact
  // word-aligned offsets match.
  always_comb begin
    offset_s    = IOBUS_ADDR - BASE_ADDR;
    wr_ctrl_s   = IOBUS_WR && (offset_s == 32'h0000_0000);
    wr_load_s   = IOBUS_WR && (offset_s == 32'h0000_0004);
    wr_status_s = IOBUS_WR && (offset_s == 32'h0000_000C);
    wr_presc_s  = IOBUS_WR && (offset_s == 32'h0000_0010);
    case (offset_s)
      32'h0000_0000: IOBUS_IN = {29'd0, ctrl_q};
      32'h0000_0004: IOBUS_IN = load_q;
      32'h0000_0008: IOBUS_IN = count_q;
      32'h0000_000C: IOBUS_IN = {30'd0, (state_q == ST_RUN), pend_q};
      32'h0000_0010: IOBUS_IN = {16'd0, presc_q};
      default:       IOBUS_IN = 32'h0000_0000;
    endcase
  end

  // Next-state logic: prescaler, count/expiry FSM, then bus writes, which
  // take priority over the FSM except that an expiry always sets PEND.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    psc_d   = psc_q;
    pend_d  = pend_q;
    tick_s  = 1'b0;

    if (wr_load_s) begin
      load_d = IOBUS_OUT;
    end else begin
      load_d = load_q;
    end

    if (wr_presc_s) begin
      presc_d = IOBUS_OUT[15:0];
    end else begin
      presc_d = presc_q;
    end

    // A prescaler above a freshly lowered PRESC wraps without ticking.
    if (state_q == ST_RUN) begin
      tick_s = (psc_q == presc_q);
      if (psc_q >= presc_q) begin
        psc_d = 16'd0;
      end else begin
        psc_d = psc_q + 16'd1;
      end
    end else begin
      psc_d = 16'd0;
    end

    // Clear first so that a simultaneous expiry below wins.
    if (wr_status_s && IOBUS_OUT[0]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_DONE: state_d = ST_DONE;
      ST_RUN: begin
        if (tick_s) begin
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else begin
            pend_d = 1'b1;
            if (ctrl_q[1]) begin
              count_d = load_q;
            end else begin
              state_d   = ST_DONE;
              ctrl_d[0] = 1'b0;
            end
          end
        end else begin
          count_d = count_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ctrl_s) begin
      if (IOBUS_OUT[0]) begin
        if (state_q == ST_RUN) begin
          // Already counting: only the mode bits change.
          ctrl_d[2:1] = IOBUS_OUT[2:1];
        end else begin
          ctrl_d  = IOBUS_OUT[2:0];
          count_d = load_q;
          psc_d   = 16'd0;
          state_d = ST_RUN;
        end
      end else begin
        ctrl_d  = IOBUS_OUT[2:0];
        count_d = count_q;
        psc_d   = 16'd0;
        state_d = ST_IDLE;
      end
    end else begin
      ctrl_d = ctrl_d;
    end

    // Interrupt flop sees the same next values as PEND and IRQ_EN, so it
    // tracks them without a cycle of lag and with no bus-to-pin path.
    intr_d = pend_d & ctrl_d[2];
  end

  // State and register update with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      presc_q <= 16'd0;
      psc_q   <= 16'd0;
      pend_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      psc_q   <= psc_d;
      pend_q  <= pend_d;
      intr_q  <= intr_d;
    end
  end

  assign INTR = intr_q;

endmodule

// File: tb/tb_iobus_timer_intc.sv
// Directed testbench for iobus_timer_intc.
`timescale 1ns/1ps

module tb_iobus_timer_intc;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_LOAD   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] IOBUS_ADDR = 32'h0;
  logic [31:0] IOBUS_OUT = 32'h0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_v;

  iobus_timer_intc #(.BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN),
    .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write, taking effect on the next rising edge; returns 1ns after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    #1;
    rd_v = IOBUS_IN;
    check(tag, rd_v, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0);
    check("rst_intr", {31'd0, INTR}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step(1);
    rd_chk("post_rst_count", A_COUNT, 32'h0);

    // Decode: stray writes change nothing and read as zero
    wr(A_LOAD, 32'hA5A5_A5A5);
    wr(A_PRESC, 32'h0000_0003);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    wr(BASE + 32'h02, 32'hFFFF_FFFF);
    wr(BASE - 32'h4, 32'hFFFF_FFFF);
    rd_chk("dec_ctrl", A_CTRL, 32'h0);
    rd_chk("dec_load", A_LOAD, 32'hA5A5_A5A5);
    rd_chk("dec_count", A_COUNT, 32'h0);
    rd_chk("dec_status", A_STATUS, 32'h0);
    rd_chk("dec_presc", A_PRESC, 32'h0000_0003);
    rd_chk("dec_rd_14", BASE + 32'h14, 32'h0);
    rd_chk("dec_rd_02", BASE + 32'h02, 32'h0);
    rd_chk("dec_rd_m4", BASE - 32'h4, 32'h0);

    // IRQ masking: LOAD=0 expires on first tick, INTR masked
    wr(A_LOAD, 32'h0);
    wr(A_PRESC, 32'h0);
    wr(A_CTRL, 32'h1);
    step(1);
    rd_chk("mask_status", A_STATUS, 32'h1);
    check("mask_intr0", {31'd0, INTR}, 32'h0);
    wr(A_CTRL, 32'h4);
    check("mask_intr1", {31'd0, INTR}, 32'h1);
    rd_chk("mask_status2", A_STATUS, 32'h1);
    wr(A_STATUS, 32'h1);
    check("mask_clr_intr", {31'd0, INTR}, 32'h0);
    rd_chk("mask_clr_status", A_STATUS, 32'h0);

    // One-shot: LOAD=3, PRESC=0 -> PEND exactly 4 edges after the write
    wr(A_LOAD, 32'h3);
    wr(A_CTRL, 32'h5);
    step(3);
    rd_chk("os_e3_status", A_STATUS, 32'h2);
    check("os_e3_intr", {31'd0, INTR}, 32'h0);
    step(1);
    rd_chk("os_e4_status", A_STATUS, 32'h1);
    check("os_e4_intr", {31'd0, INTR}, 32'h1);
    rd_chk("os_ctrl", A_CTRL, 32'h4);
    rd_chk("os_count", A_COUNT, 32'h0);
    wr(A_STATUS, 32'h1);

    // Auto-reload with prescale: period (1+1)*(2+1) = 6
    wr(A_LOAD, 32'h1);
    wr(A_PRESC, 32'h2);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        step(5);
      end else begin
        wr(A_STATUS, 32'h1);
        step(4);
      end
      rd_chk("ar_before", A_STATUS, 32'h2);
      step(1);
      rd_chk("ar_pend", A_STATUS, 32'h3);
      check("ar_intr", {31'd0, INTR}, 32'h1);
    end

    // W1C in the same cycle as an expiry: set wins
    wr(A_STATUS, 32'h1);
    rd_chk("sim_cleared", A_STATUS, 32'h2);
    step(4);
    wr(A_STATUS, 32'h1);
    rd_chk("sim_status", A_STATUS, 32'h3);
    check("sim_intr", {31'd0, INTR}, 32'h1);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    rd_chk("stop_status", A_STATUS, 32'h0);
    check("stop_intr", {31'd0, INTR}, 32'h0);

    // Reset mid-count
    wr(A_LOAD, 32'd100);
    wr(A_PRESC, 32'h0);
    wr(A_CTRL, 32'h5);
    step(50);
    rd_chk("mid_count", A_COUNT, 32'd50);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    rd_chk("mrst_ctrl", A_CTRL, 32'h0);
    rd_chk("mrst_load", A_LOAD, 32'h0);
    rd_chk("mrst_count", A_COUNT, 32'h0);
    rd_chk("mrst_presc", A_PRESC, 32'h0);
    check("mrst_intr", {31'd0, INTR}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    IOBUS_ADDR = A_STATUS;
    for (int i = 0; i < 200; i++) begin
      step(1);
      check("mrst_quiet_intr", {31'd0, INTR}, 32'h0);
      check("mrst_quiet_status", IOBUS_IN, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iobus_timer_intc.md
IOBUS_TIMER_INTC -- requirements
Module: iobus_timer_intc

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1100_0100, byte address of the register window.
REQ-002 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port IOBUS_ADDR  in  32  byte address from the CPU.
REQ-005 SHALL have port IOBUS_OUT  in  32  write data from the CPU.
REQ-006 SHALL have port IOBUS_WR  in  1  write strobe, qualified by address match, one write per high cycle.
REQ-007 SHALL have port IOBUS_IN  out  32  read data to the CPU.
REQ-008 SHALL have port INTR  out  1  level interrupt request to the CPU.

Function
REQ-009 SHALL decode five word registers at BASE_ADDR + offset:
- 0x00 CTRL (bit0 EN, bit1 AUTO, bit2 IRQ_EN).
- 0x04 LOAD (32b).
- 0x08 COUNT (read-only).
- 0x0C STATUS (bit0 PEND, W1C; bit1 RUNNING, read-only).
- 0x10 PRESC (16b).
REQ-010 SHALL return read data combinationally from IOBUS_ADDR; unused bits read 0; addresses outside the window or at unmapped offsets read 32'h0.
REQ-011 SHALL ignore writes when the address is outside the window, is unmapped, or has IOBUS_ADDR[1:0] != 0, and when the target is COUNT.
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; RUNNING = (state == RUN).
REQ-013 SHALL, on a CTRL write with EN=1 from IDLE or DONE, load COUNT<=LOAD, clear the prescaler and enter RUN on the next edge.
REQ-014 SHALL, on a CTRL write with EN=0 in any state, enter IDLE; COUNT holds its value and PEND is unaffected.
REQ-015 SHALL, on a CTRL write with EN=1 while in RUN, update AUTO and IRQ_EN only, without restarting the count.
REQ-016 SHALL keep a 16b prescaler in RUN that counts 0..PRESC and emits a one-cycle tick when it equals PRESC, then wraps to 0; PRESC=0 gives a tick every cycle.
REQ-017 SHALL, on a tick with COUNT != 0, decrement COUNT by 1.
REQ-018 SHALL, on a tick with COUNT == 0 (expiry), set PEND; then:
- AUTO=1: COUNT<=LOAD and remain in RUN.
- AUTO=0: enter DONE and clear CTRL.EN.
REQ-019 SHALL treat LOAD=0 as expiry on the first tick after start; with AUTO=1 it expires on every tick.
REQ-020 SHALL apply a LOAD write during RUN only at the next start or reload; the current COUNT is not altered.
REQ-021 SHALL apply a PRESC write immediately; if the prescaler exceeds the new PRESC, it wraps to 0 on the next edge without a tick.
REQ-022 SHALL clear PEND on a STATUS write with bit0=1; when the clear and an expiry occur in the same cycle, the set wins.
REQ-023 SHALL drive INTR = PEND & IRQ_EN from registered state only, with no combinational path from the IOBUS inputs; INTR holds until PEND is cleared or IRQ_EN is cleared.
REQ-024 SHALL count expiry at COUNT==0 on a tick, giving a period of (LOAD+1)*(PRESC+1) cycles from start to first PEND.

Reset
REQ-025 SHALL, while RESET_N=0, asynchronously force state=IDLE and CTRL, LOAD, COUNT, PRESC, PEND and the prescaler to 0, so INTR=0 and all register reads return 0.
REQ-026 SHALL abort an in-progress count on reset mid-operation, with no PEND or INTR after release; operation restarts only on a new CTRL write with EN=1.

Verification
REQ-027 SHALL cover one-shot: LOAD=3, PRESC=0, CTRL=0x5 -> PEND and INTR=1 exactly 4 cycles after the write edge; state DONE; CTRL.EN reads 0; COUNT reads 0.
REQ-028 SHALL cover auto-reload with prescale: LOAD=1, PRESC=2, CTRL=0x7, then STATUS W1C after each PEND -> PEND sets every 6 cycles, repeatedly.
REQ-029 SHALL cover the simultaneous case: a W1C of STATUS issued in the exact cycle of an expiry -> PEND remains 1 and INTR stays 1.
REQ-030 SHALL cover decode: a write of 0xFFFF_FFFF to BASE_ADDR+0x08, to BASE_ADDR+0x14, to BASE_ADDR+0x02 and to BASE_ADDR-4 -> no register changes; reads of those addresses return 0.
REQ-031 SHALL cover IRQ masking: CTRL=0x1 with LOAD=0 -> PEND=1, INTR=0; then set IRQ_EN -> INTR=1 the cycle after the write.
REQ-032 SHALL cover reset mid-count: LOAD=100 running, RESET_N pulsed low at count 50 -> all registers read 0, INTR=0, and no expiry over 200 subsequent cycles.
